// File: rtl/lzc_pipe.sv
// Two-stage pipelined leading-zero counter with valid/ready handshake and tag pass-through.
// Optional normalised-operand output is enabled by defining LZC_PIPE_NORM_EN.
module lzc_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_z,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
`ifdef LZC_PIPE_NORM_EN
    ,
    output logic [WIDTH-1:0] out_norm
`endif
);

    localparam int G = WIDTH / 8;

    logic                  s1_valid_q, s1_valid_d;
    logic [G-1:0]          s1_nz_q;
    logic [G-1:0][2:0]     s1_cnt_q;
    logic [TAG_W-1:0]      s1_tag_q;

    logic                  out_valid_q, out_valid_d;
    logic [CW-1:0]         out_z_q, out_z_d;
    logic                  out_zero_q, out_zero_d;
    logic [TAG_W-1:0]      out_tag_q;

    logic                  s1_load;
    logic                  s2_adv;
    logic [G-1:0]          grp_nz_c;
    logic [G-1:0][2:0]     grp_cnt_c;

`ifdef LZC_PIPE_NORM_EN
    logic [WIDTH-1:0]      s1_data_q;
    logic [WIDTH-1:0]      out_norm_q, out_norm_d;
`endif

    assign s2_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_adv;
    assign s1_load  = in_valid && in_ready;

    // Group 0 is the most significant byte.
    always_comb begin
        grp_nz_c  = '0;
        grp_cnt_c = '0;
        for (int g = 0; g < G; g++) begin
            for (int j = 0; j < 8; j++) begin
                if (!grp_nz_c[g] && in_data[WIDTH-1-8*g-j]) begin
                    grp_cnt_c[g] = 3'(j);
                    grp_nz_c[g]  = 1'b1;
                end
            end
        end
    end

    // Descending scan so the most significant nonzero group wins.
    always_comb begin
        out_z_d = '0;
        for (int g = G - 1; g >= 0; g--) begin
            if (s1_nz_q[g]) begin
                out_z_d = CW'(8 * g) + CW'(s1_cnt_q[g]);
            end
        end
        out_zero_d = ~|s1_nz_q;
    end

`ifdef LZC_PIPE_NORM_EN
    assign out_norm_d = s1_data_q << out_z_d;
`endif

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        out_valid_d = out_valid_q;
        if (s2_adv) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_zero_q  <= 1'b0;
            out_tag_q   <= '0;
`ifdef LZC_PIPE_NORM_EN
            out_norm_q  <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (s2_adv) begin
                out_z_q    <= out_z_d;
                out_zero_q <= out_zero_d;
                out_tag_q  <= s1_tag_q;
`ifdef LZC_PIPE_NORM_EN
                out_norm_q <= out_norm_d;
`endif
            end
        end
    end

    // S1 payload needs no reset: it is only consumed while s1_valid_q is set.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_nz_q   <= grp_nz_c;
            s1_cnt_q  <= grp_cnt_c;
            s1_tag_q  <= in_tag;
`ifdef LZC_PIPE_NORM_EN
            s1_data_q <= in_data;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign out_zero  = out_zero_q;
    assign out_tag   = out_tag_q;
`ifdef LZC_PIPE_NORM_EN
    assign out_norm  = out_norm_q;
`endif

endmodule

// File: tb/tb_lzc_pipe.sv
// Self-checking bench for lzc_pipe: queue-based reference model checked every cycle,
// directed literal cases, backpressure, streaming, reset and a width sweep.
module tb_lzc_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_z;
    logic        out_zero;
    logic [3:0]  out_tag;
`ifdef LZC_PIPE_NORM_EN
    logic [31:0] out_norm;
`endif

    lzc_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .out_zero(out_zero), .out_tag(out_tag)
`ifdef LZC_PIPE_NORM_EN
        , .out_norm(out_norm)
`endif
    );

    // Width-sweep instances share one stimulus stream.
    logic        sw_valid = 1'b0;
    logic        sw_tag = 1'b0;
    logic [7:0]  sw_d8 = '0;
    logic [15:0] sw_d16 = '0;
    logic [63:0] sw_d64 = '0;
    logic        rdy8, rdy16, rdy64, ov8, ov16, ov64, zr8, zr16, zr64, tg8, tg16, tg64;
    logic [2:0]  z8;
    logic [3:0]  z16;
    logic [5:0]  z64;
`ifdef LZC_PIPE_NORM_EN
    logic [7:0]  nm8;
    logic [15:0] nm16;
    logic [63:0] nm64;
`endif

    lzc_pipe #(.WIDTH(8), .TAG_W(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy8), .in_data(sw_d8),
        .in_tag(sw_tag), .out_valid(ov8), .out_ready(1'b1), .out_z(z8), .out_zero(zr8),
        .out_tag(tg8)
`ifdef LZC_PIPE_NORM_EN
        , .out_norm(nm8)
`endif
    );
    lzc_pipe #(.WIDTH(16), .TAG_W(1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy16), .in_data(sw_d16),
        .in_tag(sw_tag), .out_valid(ov16), .out_ready(1'b1), .out_z(z16), .out_zero(zr16),
        .out_tag(tg16)
`ifdef LZC_PIPE_NORM_EN
        , .out_norm(nm16)
`endif
    );
    lzc_pipe #(.WIDTH(64), .TAG_W(1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy64), .in_data(sw_d64),
        .in_tag(sw_tag), .out_valid(ov64), .out_ready(1'b1), .out_z(z64), .out_zero(zr64),
        .out_tag(tg64)
`ifdef LZC_PIPE_NORM_EN
        , .out_norm(nm64)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit en = 0;
    bit lat_en = 0;
    bit saw_block = 0;
    bit last_acc = 0;
    int ready_mode = 0;

    int          q_z[$], q_zero[$], q_tag[$], q_acc[$];
    logic [31:0] q_norm[$];
    int          log_z[$], log_zero[$], log_tag[$], log_cyc[$];
    logic [31:0] log_norm[$];

    bit          prev_stall = 0;
    logic [4:0]  prev_z;
    logic        prev_zero;
    logic [3:0]  prev_tag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_lz(input logic [63:0] d, input int w);
        int r = 0;
        bit f = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (!f && d[i]) begin
                r = w - 1 - i;
                f = 1;
            end
        end
        return r;
    endfunction

    // Capacity is two; a lone item becomes visible two cycles after its accept cycle.
    always @(negedge clk) begin
        if (en) begin
            int  n;
            bit  exp_ov;
            n = q_z.size();
            exp_ov = (n == 2) || (n == 1 && q_acc[0] <= cyc - 2);
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, (n < 2) || out_ready);
            chk("occupancy", n <= 2, 1);
            if (!in_ready) saw_block = 1;
            if (out_valid && n > 0) begin
                chk("out_z", out_z, q_z[0]);
                chk("out_zero", out_zero, q_zero[0]);
                chk("out_tag", out_tag, q_tag[0]);
`ifdef LZC_PIPE_NORM_EN
                chk("out_norm", out_norm, q_norm[0]);
`endif
            end
            if (prev_stall) begin
                chk("stall_hold_z", out_z, prev_z);
                chk("stall_hold_zero", out_zero, prev_zero);
                chk("stall_hold_tag", out_tag, prev_tag);
            end
            if (rst) begin
                q_z.delete(); q_zero.delete(); q_tag.delete(); q_acc.delete(); q_norm.delete();
                prev_stall = 0;
            end else begin
                if (out_valid && out_ready && n > 0) begin
                    if (lat_en) chk("latency", cyc - q_acc[0], 2);
                    log_z.push_back(q_z[0]);
                    log_zero.push_back(q_zero[0]);
                    log_tag.push_back(int'(out_tag));
                    log_cyc.push_back(cyc);
`ifdef LZC_PIPE_NORM_EN
                    log_norm.push_back(out_norm);
`endif
                    void'(q_z.pop_front()); void'(q_zero.pop_front());
                    void'(q_tag.pop_front()); void'(q_acc.pop_front());
                    void'(q_norm.pop_front());
                end
                if (in_valid && in_ready) begin
                    q_z.push_back(ref_lz({32'h0, in_data}, 32));
                    q_zero.push_back(in_data == 32'h0);
                    q_tag.push_back(int'(in_tag));
                    q_acc.push_back(cyc);
                    q_norm.push_back(in_data << ref_lz({32'h0, in_data}, 32));
                end
                prev_stall = out_valid && !out_ready;
                prev_z     = out_z;
                prev_zero  = out_zero;
                prev_tag   = out_tag;
            end
        end
        cyc++;
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 3 == 0);
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic step();
        @(negedge clk);
        last_acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] t);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        do begin
            step();
            k++;
        end while (!last_acc && k < 100);
        if (!last_acc) begin
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic drain();
        int k = 0;
        in_valid = 1'b0;
        while (q_z.size() != 0 && k < 200) begin
            step();
            k++;
        end
        if (q_z.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", q_z.size());
        end
        repeat (2) step();
    endtask

    task automatic clear_logs();
        log_z.delete(); log_zero.delete(); log_tag.delete(); log_cyc.delete(); log_norm.delete();
    endtask

    function automatic logic [31:0] rand_op();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 32'h0;
        return $urandom >> $urandom_range(0, 31);
    endfunction

    logic [31:0] dir_op[11];
    int          dir_z[11];

    initial begin
        dir_op = '{32'h0, 32'h1, 32'h2, 32'h8000, 32'h00800000, 32'h80000000,
                   32'h40000000, 32'hF, 32'h10, 32'h80, 32'hFFFFFFFF};
        dir_z  = '{0, 31, 30, 16, 8, 0, 1, 28, 27, 24, 0};

        @(posedge clk); #1;
        en = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_z", out_z, 0);
        chk("reset_out_zero", out_zero, 0);
        chk("reset_out_tag", out_tag, 0);
`ifdef LZC_PIPE_NORM_EN
        chk("reset_out_norm", out_norm, 0);
`endif
        @(posedge clk); #1;

        // Directed literal cases
        lat_en = 1;
        clear_logs();
        for (int i = 0; i < 11; i++) send(dir_op[i], 4'(i));
        drain();
        chk("dir_count", log_z.size(), 11);
        for (int i = 0; i < 11; i++) begin
            chk("model_pin", ref_lz({32'h0, dir_op[i]}, 32), dir_z[i]);
            chk("dir_z", log_z[i], dir_z[i]);
            chk("dir_zero", log_zero[i], (i == 0) ? 1 : 0);
            chk("dir_tag", log_tag[i], i);
        end

        clear_logs();
        send(32'h00012345, 4'h7);
        drain();
        chk("norm_case_z", log_z[0], 15);
`ifdef LZC_PIPE_NORM_EN
        chk("norm_case_norm", log_norm[0], 32'h91A28000);
`endif

        // Back-to-back streaming
        clear_logs();
        for (int i = 0; i < 16; i++) send(rand_op(), 4'(i));
        drain();
        chk("stream_count", log_z.size(), 16);
        for (int i = 1; i < 16; i++) chk("stream_consecutive", log_cyc[i] - log_cyc[0], i);

        // Backpressure with out_ready pattern 1,0,0
        lat_en = 0;
        saw_block = 0;
        ready_mode = 1;
        clear_logs();
        for (int i = 0; i < 6; i++) send(rand_op(), 4'(i));
        drain();
        ready_mode = 0;
        chk("bp_count", log_tag.size(), 6);
        for (int i = 0; i < 6; i++) chk("bp_order", log_tag[i], i);
        chk("bp_in_ready_dropped", saw_block, 1);

        // Reset while both stages are full
        ready_mode = 3;
        step();
        send(32'h00F0_0000, 4'h1);
        send(32'h0000_0100, 4'h2);
        in_valid = 1'b0;
        step();
        chk("full_before_reset", q_z.size(), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_logs();
        @(negedge clk);
        chk("post_reset_out_valid", out_valid, 0);
        chk("post_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        ready_mode = 0;
        repeat (6) step();
        chk("no_stale_result", log_z.size(), 0);

        // Randomised traffic
        ready_mode = 2;
        in_valid = 1'b0;
        last_acc = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = rand_op();
                in_tag   = 4'($urandom);
            end
            step();
        end
        ready_mode = 0;
        drain();

        // Width sweep: walking one from MSB, then an all-zero operand
        for (int i = 0; i <= 67; i++) begin
            sw_valid = (i <= 64);
            sw_tag   = 1'(i);
            sw_d8    = (i < 8)  ? (8'h80 >> i) : 8'h0;
            sw_d16   = (i < 16) ? (16'h8000 >> i) : 16'h0;
            sw_d64   = (i < 64) ? (64'h8000_0000_0000_0000 >> i) : 64'h0;
            @(negedge clk);
            chk("sw_ready8", rdy8, 1);
            chk("sw_ready64", rdy64, 1);
            chk("sw_valid8", ov8, (i >= 2 && i <= 66));
            chk("sw_valid16", ov16, (i >= 2 && i <= 66));
            chk("sw_valid64", ov64, (i >= 2 && i <= 66));
            if (i >= 2 && i <= 66) begin
                int j;
                j = i - 2;
                chk("sw_z8", z8, (j < 8) ? j : 0);
                chk("sw_zero8", zr8, (j < 8) ? 0 : 1);
                chk("sw_z16", z16, (j < 16) ? j : 0);
                chk("sw_zero16", zr16, (j < 16) ? 0 : 1);
                chk("sw_z64", z64, (j < 64) ? j : 0);
                chk("sw_zero64", zr64, (j < 64) ? 0 : 1);
                chk("sw_tag16", tg16, j % 2);
                chk("sw_tag8_64", {tg8, tg64}, (j % 2) * 3);
                if (j % 2 == 1) chk("sw_ready16", rdy16, 1);
            end
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

`ifdef LZC_PIPE_NORM_EN
    logic nm_unused;
    assign nm_unused = ^{nm8, nm16, nm64};
`endif

endmodule
